param_sync_fifo: RTL
====================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter W, default 8: data width in bits, W>=1.
REQ-002 Parameter D, default 4: depth in entries, power of two, D>=2.
REQ-003 Parameter AF, default D-1: almost-full threshold, 1<=AF<=D.
REQ-004 Parameter AE, default 1: almost-empty threshold, 0<=AE<D.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 wr_data  in  W  write data.
REQ-008 wr_en  in  1  write request.
REQ-009 wr_full  out  1  registered; FIFO holds D entries.
REQ-010 wr_almost_full  out  1  registered; count>=AF.
REQ-011 rd_data  out  W  head-of-queue data (first-word fall-through).
REQ-012 rd_en  in  1  read request.
REQ-013 rd_empty  out  1  registered; FIFO holds 0 entries.
REQ-014 rd_almost_empty  out  1  registered; count<=AE.
REQ-015 count  out  $clog2(D)+1  registered occupancy, 0..D.
REQ-016 overflow  out  1  sticky; wr_en asserted while wr_full.
REQ-017 underflow  out  1  sticky; rd_en asserted while rd_empty.

Function
REQ-018 writing = wr_en & ~wr_full; reading = rd_en & ~rd_empty; only these qualified strobes change state.
REQ-019 Read and write pointers are $clog2(D)+1 bits; the MSB is the wrap bit; the low bits index storage; wrap from D-1 to 0 is natural binary rollover.
REQ-020 Next-pointer values are combinational; flags and count are registered from next-pointer values, so all status outputs are valid the cycle after the accepting edge, with no extra lag.
REQ-021 Empty when next pointers are equal; full when low bits are equal and wrap bits differ.
REQ-022 count = next_wr_ptr - next_rd_ptr modulo 2^($clog2(D)+1), registered.
REQ-023 rd_data is driven combinationally from storage[rd_ptr low bits]; written data appears on rd_data one cycle after the write that makes rd_empty fall.
REQ-024 Simultaneous reading and writing when neither full nor empty: both pointers advance, count unchanged, flags unchanged.
REQ-025 wr_en and rd_en asserted together while full: read accepted, write dropped; wr_full deasserts next cycle.
REQ-026 wr_en and rd_en asserted together while empty: write accepted, read ignored; rd_empty deasserts next cycle.
REQ-027 Storage is written only on writing and is not reset; rd_data is don't-care while rd_empty=1.

Reset
REQ-028 While reset=1, pointers go to 0, rd_empty=1, wr_full=0, rd_almost_empty=1, wr_almost_full=(AF==0 ? 1 : 0), i.e. 0 for legal AF, count=0, overflow=0, underflow=0.
REQ-029 Reset has priority over wr_en/rd_en in the same cycle; contents in flight are discarded.

Configuration
REQ-030 Macro PARAM_SYNC_FIFO_ERR_FLAGS_EN defined: overflow/underflow set on the first offending cycle, held until reset.
REQ-031 Macro undefined: overflow and underflow are tied to 0; the ports remain present and no error-flag logic is generated.

Structure
REQ-032 Package sync_fifo_pkg holds the pointer-width function (clog2(D)+1) and the status struct type {full, almost_full, empty, almost_empty}.
REQ-033 One sub-module fifo_ptr_ctr (parametrised pointer with next-value output, synchronous reset, increment enable) is instantiated twice, once for read and once for write.

Verification (W=8, D=4, AF=3, AE=1)
REQ-034 Reset, then write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; wr_almost_full rises with count=3; wr_full=1 after fourth write; rd_empty falls after first write.
REQ-035 From full, read four times -> rd_data 0x11,0x22,0x33,0x44 in order; rd_empty=1 and count=0 after last read.
REQ-036 Ten cycles of simultaneous read+write at count=2 -> count stays 2, data order preserved across pointer wrap.
REQ-037 wr_en while full with value 0xEE -> 0xEE never read; overflow=1 and sticky with macro, 0 without; likewise rd_en while empty sets underflow.
REQ-038 Reset asserted at count=3 -> next cycle rd_empty=1, wr_full=0, count=0, overflow/underflow=0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for param_sync_fifo: the pointer width and the status flag bundle.
package sync_fifo_pkg;

    // One extra bit beyond the index width is used to tell full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Wrapping FIFO pointer. The next value is exposed combinationally so that the
// parent can register its flags from it without an extra cycle of lag.
module fifo_ptr_ctr #(
    parameter int PW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_inc,
    output logic [PW-1:0] o_ptr,
    output logic [PW-1:0] o_ptr_nxt
);

    logic [PW-1:0] r_ptr;

    // Depth is a power of two, so binary rollover of the low bits is the wrap.
    assign o_ptr_nxt = r_ptr + PW'(i_inc);
    assign o_ptr     = r_ptr;

    always_ff @(posedge clk) begin
        if (reset) r_ptr <= '0;
        else       r_ptr <= o_ptr_nxt;
    end

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered status flags and count.
// Define PARAM_SYNC_FIFO_ERR_FLAGS_EN to enable sticky overflow/underflow flags.
module param_sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int W  = 8,
    parameter int D  = 4,
    parameter int AF = D - 1,
    parameter int AE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [W-1:0]         wr_data,
    input  logic                 wr_en,
    output logic                 wr_full,
    output logic                 wr_almost_full,
    output logic [W-1:0]         rd_data,
    input  logic                 rd_en,
    output logic                 rd_empty,
    output logic                 rd_almost_empty,
    output logic [ptr_w(D)-1:0]  count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int PW = ptr_w(D);
    localparam int AW = PW - 1;

    fifo_status_t  r_status;
    logic [PW-1:0] r_count;
    logic [W-1:0]  r_mem [D];

    logic          w_writing, w_reading;
    logic [PW-1:0] w_wr_ptr, w_wr_nxt, w_rd_ptr, w_rd_nxt, w_cnt_nxt;

    assign w_writing = wr_en & ~r_status.full;
    assign w_reading = rd_en & ~r_status.empty;

    fifo_ptr_ctr #(.PW(PW)) u_wr_ptr (
        .clk       (clk),
        .reset     (reset),
        .i_inc     (w_writing),
        .o_ptr     (w_wr_ptr),
        .o_ptr_nxt (w_wr_nxt)
    );

    fifo_ptr_ctr #(.PW(PW)) u_rd_ptr (
        .clk       (clk),
        .reset     (reset),
        .i_inc     (w_reading),
        .o_ptr     (w_rd_ptr),
        .o_ptr_nxt (w_rd_nxt)
    );

    assign w_cnt_nxt = w_wr_nxt - w_rd_nxt;

    always_ff @(posedge clk) begin
        if (w_writing) r_mem[w_wr_ptr[AW-1:0]] <= wr_data;
    end

    // Flags come from the next pointers, so they are valid right after the accepting edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_status.full         <= 1'b0;
            r_status.almost_full  <= (AF == 0);
            r_status.empty        <= 1'b1;
            r_status.almost_empty <= 1'b1;
            r_count               <= '0;
        end else begin
            r_status.full         <= (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]) &&
                                     (w_wr_nxt[AW] != w_rd_nxt[AW]);
            r_status.almost_full  <= (w_cnt_nxt >= PW'(AF));
            r_status.empty        <= (w_wr_nxt == w_rd_nxt);
            r_status.almost_empty <= (w_cnt_nxt <= PW'(AE));
            r_count               <= w_cnt_nxt;
        end
    end

`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
    logic r_overflow, r_underflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= r_overflow  | (wr_en & r_status.full);
            r_underflow <= r_underflow | (rd_en & r_status.empty);
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign wr_full         = r_status.full;
    assign wr_almost_full  = r_status.almost_full;
    assign rd_empty        = r_status.empty;
    assign rd_almost_empty = r_status.almost_empty;
    assign count           = r_count;
    assign rd_data         = r_mem[w_rd_ptr[AW-1:0]];

endmodule
